// File: rtl/dc_mem_queue.sv
// In-order load/store queue feeding the data cache processor port.
// Retries the head op on a miss and returns tagged responses one cycle after completion.
module dc_mem_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned STALL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic                     flush,
  output logic [31:0]              dc_addr,
  output logic [31:0]              dc_wdata,
  output logic                     dc_write,
  output logic                     dc_read,
  input  logic [31:0]              dc_rdata,
  input  logic                     dc_miss,
  output logic                     rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_write,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [STALL_W-1:0]       stall_cycles
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      data_mem  [DEPTH];
  logic             write_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [31:0]      head_addr, head_data;
  logic             head_write;
  logic [TAG_W-1:0] head_tag;
  logic             empty, full, head_misaligned, issue, push, pop;

  always_comb begin
    head_addr       = addr_mem[rd_ptr_q];
    head_data       = data_mem[rd_ptr_q];
    head_write      = write_mem[rd_ptr_q];
    head_tag        = tag_mem[rd_ptr_q];
    empty           = (count_q == '0);
    full            = (count_q == CW'(DEPTH));
    head_misaligned = (head_addr[1:0] != 2'b00);
    issue           = !empty && !head_misaligned;

    dc_addr   = '0;
    dc_wdata  = '0;
    dc_write  = 1'b0;
    dc_read   = 1'b0;
    if (issue) begin
      dc_addr  = head_addr;
      dc_wdata = head_write ? head_data : '0;
      dc_write = head_write;
      dc_read  = !head_write;
    end

    // Misaligned heads drain without touching the cache; aligned ones wait out misses.
    pop       = !empty && (head_misaligned || !dc_miss);
    req_ready = !rst && !full && !flush;
    push      = req_valid && req_ready;
    occupancy = count_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= req_addr;
      data_mem[wr_ptr_q]  <= req_data;
      write_mem[wr_ptr_q] <= req_write;
      tag_mem[wr_ptr_q]   <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stall_cycles <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_write    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end

      if (issue && dc_miss && (stall_cycles != '1)) stall_cycles <= stall_cycles + STALL_W'(1);

      rsp_valid <= pop && !flush;
      if (pop && !flush) begin
        rsp_tag   <= head_tag;
        rsp_write <= head_write;
        rsp_err   <= head_misaligned;
        rsp_data  <= (issue && !head_write) ? dc_rdata : '0;
      end
    end
  end

endmodule
